tile_spawner: RTL and testbench
===============================

Name: tile_spawner

Overview:
- Downstream stage of the 2048 move/merge logic. After each accepted move (and twice at game start), it places one new tile (2 or 4) in a pseudo-randomly chosen empty cell of the 4x4 board.
- The updated board is returned to the game top, where it feeds the matrix register and the win/lose detection.
- Randomness comes from a free-running 16-bit LFSR. Cell search is sequential, one cell per clock.

Parameters:
- SEED, 16'hACE1, LFSR reset value; must be nonzero (SEED=0 is illegal).
- FOUR_THRESH, 1, a new tile is 4 when sampled lfsr[3:0] < FOUR_THRESH, otherwise 2. Default gives 1/16 odds of a 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request one spawn; sampled only in IDLE
- board_in  in  12 x [0:3][0:3]  board after move/merge; cell value 0 = empty
- board_out  out  12 x [0:3][0:3]  board with new tile inserted
- done  out  1  one-cycle pulse; board_out, spawn_row, spawn_col and no_space are valid from this cycle on
- busy  out  1  high while in SCAN
- no_space  out  1  valid with done; 1 = board had no empty cell, no tile placed
- spawn_row  out  2  row of placed tile, valid with done
- spawn_col  out  2  column of placed tile, valid with done

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, lfsr=SEED
  - board_out all zero; done, busy, no_space, spawn_row, spawn_col = 0
  - Reset mid-SCAN aborts the spawn: no done pulse, board_out cleared.
- LFSR:
  - Fibonacci, shift left, new bit0 = b15^b13^b12^b10.
  - Advances every clock except during reset, in every state.
- States: IDLE, SCAN.
- IDLE:
  - done=0 except for the cycle immediately after SCAN exit.
  - On an edge with start=1:
    - snapshot board_in into an internal register
    - idx = lfsr[7:4] (cell index, row = idx[3:2], col = idx[1:0])
    - val = 4 if lfsr[3:0] < FOUR_THRESH, else 2
    - scanned=0, busy=1, go to SCAN
  - The pre-advance LFSR value is the one sampled at this edge.
- SCAN, one edge per cell:
  - If snap[idx]==0:
    - board_out = snap with cell idx set to val
    - spawn_row/col = idx
    - no_space=0, done=1 for one cycle, busy=0, go to IDLE
  - Else if scanned==15:
    - board_out = snap unchanged
    - no_space=1, spawn_row/col hold their previous values
    - done=1, busy=0, go to IDLE
  - Else: idx = idx+1 mod 16 (wraps 15 -> 0), scanned++.
- Latency: start edge E0; done is high in the cycle after edge E(1+k), where k = number of occupied cells visited before the first empty one (0..15). Full board: done after E16.
- start while busy is ignored, not queued. start held high re-triggers at the first IDLE edge, i.e. the cycle done is high.
- board_in changes during SCAN have no effect; only the snapshot is used.
- board_out, spawn_row/col and no_space hold their values until the next done or reset.
- Only the target cell may differ between snap and board_out. All other 15 cells must be bit-identical.

Test Plan:
- Reset: rst=1 for 2 cycles -> board_out all 0, done=0, busy=0, no_space=0. No done pulse follows until start.
- Single empty cell: board_in all 2 except [2][1]=0, pulse start -> done within 17 cycles, spawn_row=2, spawn_col=1, board_out[2][1] ∈ {2,4}, other 15 cells unchanged, no_space=0.
- Empty board, start at edge E0 -> done in the cycle after E1, busy high exactly 1 cycle. The cell equals lfsr[7:4] as predicted by a reference-model LFSR from SEED.
- Full board: all cells 8 (no empty), start -> done in the cycle after E16, no_space=1, board_out == board_in.
- Wrap-around: only cell [0][0] empty and model predicts lfsr[7:4]=15 at start -> scan visits 15 then 0, done in the cycle after E2, spawn_row=0, spawn_col=0.
- Robustness:
  - Pulse start again at the 3rd busy cycle -> ignored, exactly one done.
  - Assert rst mid-SCAN -> no done, board_out=0.
  - 1000 random spawns on an empty board -> every cell chosen at least once; the fraction of 4s is about 1/16 (±3%).

Source files
------------

// File: rtl/tile_spawner.sv
// -----------------------------------------------------------------------------
// tile_spawner
//   Places one new tile (2 or 4) into a pseudo-randomly chosen empty cell of a
//   4x4 2048 board. A free-running 16-bit Fibonacci LFSR supplies the start
//   cell and the tile value. Starting from that cell the board snapshot is
//   scanned one cell per clock, wrapping 15 -> 0, until an empty cell is found
//   or all 16 cells have been visited.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   start      request one spawn (sampled only while idle)
//   board_in   board after move/merge, 12-bit cells, 0 = empty
//   board_out  board with the new tile inserted (held until next done/reset)
//   done       one-cycle pulse; board_out/spawn_row/spawn_col/no_space valid
//   busy       high while scanning
//   no_space   with done: board had no empty cell, nothing placed
//   spawn_row  row of the placed tile
//   spawn_col  column of the placed tile
//
// SEED must be nonzero: an all-zero Fibonacci LFSR never leaves zero.
// -----------------------------------------------------------------------------
module tile_spawner #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          FOUR_THRESH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [0:3][0:3][11:0]   board_in,
  output logic [0:3][0:3][11:0]   board_out,
  output logic                    done,
  output logic                    busy,
  output logic                    no_space,
  output logic [1:0]              spawn_row,
  output logic [1:0]              spawn_col
);

  typedef enum logic {IDLE, SCAN} state_t;

  // Five bits so a threshold of 16 (always a 4) is representable.
  localparam logic [4:0] THRESH_W = 5'(FOUR_THRESH);

  state_t                  state_q;
  logic [15:0]             lfsr_q;
  logic [15:0]             lfsr_d;
  logic [0:3][0:3][11:0]   snap_q;
  logic [0:3][0:3][11:0]   board_q;
  logic [0:3][0:3][11:0]   board_ins_d;
  logic [3:0]              idx_q;
  logic [3:0]              scanned_q;
  logic [11:0]             val_q;
  logic                    done_q;
  logic                    busy_q;
  logic                    no_space_q;
  logic [1:0]              row_q;
  logic [1:0]              col_q;
  logic                    cell_empty;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [11:0] new_tile_val(input logic [3:0] r);
    return ({1'b0, r} < THRESH_W) ? 12'd4 : 12'd2;
  endfunction

  assign lfsr_d     = lfsr_step(lfsr_q);
  assign cell_empty = (snap_q[idx_q[3:2]][idx_q[1:0]] == 12'd0);

  // Snapshot with the candidate cell overwritten; every other cell passes
  // through untouched.
  always_comb begin
    board_ins_d = snap_q;
    board_ins_d[idx_q[3:2]][idx_q[1:0]] = val_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      board_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      no_space_q <= 1'b0;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      idx_q      <= 4'd0;
      scanned_q  <= 4'd0;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // The LFSR value visible at this edge (pre-advance) seeds the spawn.
            snap_q    <= board_in;
            idx_q     <= lfsr_q[7:4];
            val_q     <= new_tile_val(lfsr_q[3:0]);
            scanned_q <= 4'd0;
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (cell_empty) begin
            board_q    <= board_ins_d;
            row_q      <= idx_q[3:2];
            col_q      <= idx_q[1:0];
            no_space_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (scanned_q == 4'd15) begin
            // Full board: return it unchanged, keep last spawn position.
            board_q    <= snap_q;
            no_space_q <= 1'b1;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            idx_q     <= idx_q + 4'd1;
            scanned_q <= scanned_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign board_out = board_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign no_space  = no_space_q;
  assign spawn_row = row_q;
  assign spawn_col = col_q;

endmodule

// File: tb/tb_tile_spawner.sv
module tb_tile_spawner;

  localparam logic [15:0] SEED        = 16'hACE1;
  localparam int          FOUR_THRESH = 1;

  typedef logic [0:3][0:3][11:0] board_t;

  typedef struct {
    board_t     b;
    bit         wait15;
    bit         chk_pos;
    logic [1:0] er;
    logic [1:0] ec;
    logic       enosp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  board_t     board_in;
  board_t     board_out;
  logic       done;
  logic       busy;
  logic       no_space;
  logic [1:0] spawn_row;
  logic [1:0] spawn_col;

  int checks = 0;
  int errors = 0;

  // Reference LFSR: advances on every clock edge, reloads on reset.
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  int          m_row = 0;
  int          m_col = 0;

  tile_spawner #(.SEED(SEED), .FOUR_THRESH(FOUR_THRESH)) dut (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in),
    .board_out(board_out), .done(done), .busy(busy), .no_space(no_space),
    .spawn_row(spawn_row), .spawn_col(spawn_col)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return (s << 1) | {15'd0, fb};
  endfunction

  always @(posedge clk) begin
    m_prev = m_lfsr;
    if (rst) m_lfsr = SEED;
    else     m_lfsr = ref_step(m_lfsr);
  end

  task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  // One spawn, fully checked against the reference model.
  task automatic spawn(input board_t b, input bit wait15,
                       output int pos, output bit four, output bit nosp);
    int          guard;
    logic [15:0] L;
    int          k;
    int          eidx;
    int          elat;
    int          n;
    int          busyc;
    bit          got;
    logic [11:0] ev;
    board_t      eb;
    @(negedge clk);
    guard = 0;
    if (wait15)
      while (m_lfsr[7:4] != 4'hF && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
    board_in = b;
    start    = 1'b1;
    @(posedge clk); #1;
    L     = m_prev;
    start = 1'b0;
    // Model: first empty cell at or after L[7:4], circularly.
    eidx = int'(L[7:4]);
    k    = 16;
    pos  = -1;
    for (int j = 0; j < 16; j++) begin
      int c;
      c = (eidx + j) % 16;
      if (b[c / 4][c % 4] == 12'd0) begin
        k   = j;
        pos = c;
        break;
      end
    end
    four = (int'(L[3:0]) < FOUR_THRESH);
    ev   = four ? 12'd4 : 12'd2;
    eb   = b;
    nosp = (k == 16);
    if (!nosp) begin
      eb[pos / 4][pos % 4] = ev;
      m_row = pos / 4;
      m_col = pos % 4;
    end
    elat  = nosp ? 16 : 1 + k;
    n     = 0;
    busyc = 0;
    got   = 1'b0;
    while (!got && n < 20) begin
      if (busy) busyc++;
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
    chk("latency", n, elat);
    chk("busy_cycles", busyc, elat);
    chk("busy_at_done", busy, 0);
    chk("board_out", board_out, eb);
    chk("no_space", no_space, nosp);
    chk("spawn_row", spawn_row, m_row);
    chk("spawn_col", spawn_col, m_col);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
  endtask

  function automatic board_t fill(input logic [11:0] v);
    board_t r;
    for (int i = 0; i < 16; i++) r[i / 4][i % 4] = v;
    return r;
  endfunction

  vec_t   vecs[4];
  board_t tb;
  int     pos;
  bit     four;
  bit     nosp;
  int     hits[16];
  int     nfour;
  int     ncov;
  int     ndone;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    board_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_board", board_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nosp", no_space, 0);
    chk("rst_rowcol", {spawn_row, spawn_col}, 0);
    rst   = 1'b0;
    ndone = 0;
    repeat (6) begin @(negedge clk); if (done) ndone++; end
    chk("no_done_idle", ndone, 0);

    // Directed table
    vecs[0] = '{b: fill(12'd0), wait15: 0, chk_pos: 0, er: 0, ec: 0, enosp: 0};
    tb = fill(12'd2); tb[2][1] = 12'd0;
    vecs[1] = '{b: tb, wait15: 0, chk_pos: 1, er: 2, ec: 1, enosp: 0};
    vecs[2] = '{b: fill(12'd8), wait15: 0, chk_pos: 0, er: 0, ec: 0, enosp: 1};
    tb = fill(12'd2); tb[0][0] = 12'd0;
    vecs[3] = '{b: tb, wait15: 1, chk_pos: 1, er: 0, ec: 0, enosp: 0};
    for (int v = 0; v < 4; v++) begin
      spawn(vecs[v].b, vecs[v].wait15, pos, four, nosp);
      chk($sformatf("vec%0d_nosp", v), no_space, vecs[v].enosp);
      if (vecs[v].chk_pos) begin
        chk($sformatf("vec%0d_row", v), spawn_row, vecs[v].er);
        chk($sformatf("vec%0d_col", v), spawn_col, vecs[v].ec);
      end
    end

    // start pulsed again during the 3rd busy cycle is ignored
    @(negedge clk);
    board_in = fill(12'd8);
    start    = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    chk("ignore_start_dones", ndone, 1);
    chk("ignore_start_board", board_out, fill(12'd8));
    chk("ignore_start_busy", busy, 0);

    // Reset in the middle of a scan aborts it
    @(negedge clk);
    board_in = fill(12'd16);
    start    = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_board", board_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_nosp", no_space, 0);
    m_row = 0;
    m_col = 0;
    ndone = 0;
    repeat (25) begin @(negedge clk); if (done) ndone++; end
    chk("abort_no_done", ndone, 0);

    // 1000 random-timed spawns on an empty board
    foreach (hits[i]) hits[i] = 0;
    nfour = 0;
    for (int t = 0; t < 1000; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      spawn(fill(12'd0), 0, pos, four, nosp);
      if (pos >= 0) hits[pos]++;
      if (four) nfour++;
    end
    ncov = 0;
    foreach (hits[i]) if (hits[i] > 0) ncov++;
    chk("all_cells_hit", ncov, 16);
    chk("four_fraction_ok", (nfour >= 33 && nfour <= 92), 1);

    // Random boards, including the occasional full one
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < 16; i++)
        tb[i / 4][i % 4] = ($urandom_range(0, 1) == 0 && (t % 10) != 0)
                           ? 12'd0 : (12'd2 << $urandom_range(0, 10));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      spawn(tb, 0, pos, four, nosp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
